// File: rtl/sub_byte_arbiter.sv
// Shares one pipelined SubBytes datapath between NUM_REQ requesters and routes each result back to its owner.
// Define SUB_BYTE_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module sub_byte_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int SBOX_LAT = 1,
  parameter int DATA_W   = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]         sb_data_in,
  output logic                      sb_valid,
  input  logic [DATA_W-1:0]         sb_sub_mat,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a word moves when req_valid[i] & req_ready[i] at a rising edge; req_ready
  // depends only on req_valid (and the pointer), and at most one bit is ever high.
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;

`ifdef SUB_BYTE_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   cand;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_any && req_valid[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  // The search restarts just past the last winner, so contenders alternate strictly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end
`endif

  // Ready is forced low while reset is held, even if a requester is presenting.
  always_comb begin
    gnt = '0;
    if (gnt_any && rst) begin
      gnt = NUM_REQ'(1) << gnt_idx;
    end
  end

  assign req_ready = gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_data_in <= '0;
      sb_valid   <= 1'b0;
    end else begin
      sb_valid <= |gnt;
      if (|gnt) begin
        sb_data_in <= req_data[gnt_idx*DATA_W +: DATA_W];
      end
    end
  end

  // Stage 0 sits beside the issue register; the S-box result lines up with stage SBOX_LAT.
  logic [NUM_REQ-1:0] tag_q [SBOX_LAT+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= SBOX_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= gnt;
      for (int k = 1; k <= SBOX_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign rsp_valid = tag_q[SBOX_LAT];
  assign rsp_data  = rst ? sb_sub_mat : '0;

  always_comb begin
    busy = sb_valid;
    for (int k = 0; k <= SBOX_LAT; k++) begin
      busy = busy | (|tag_q[k]);
    end
  end

endmodule

// File: tb/tb_sub_byte_arbiter.sv
// Directed bench for sub_byte_arbiter: one instance with SBOX_LAT=1 and one with SBOX_LAT=3 share the request side.
// Expectations follow SUB_BYTE_ARB_RR_EN when it is defined for the build.
module tb_sub_byte_arbiter;

  localparam int W = 162;  // {due cycle[31:0], owner[1:0], data[127:0]}

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] VA  = 128'h001F0E543C4E08596E221B0B4774311A;
  localparam logic [127:0] SA  = 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2;
  localparam logic [127:0] VB  = 128'h5847088B15B61CBA59D4E2E8CD39DFCE;
  localparam logic [127:0] SB  = 128'h6AA0303D594E9CF4CB48989BBD129E8B;
  localparam logic [127:0] V78 = 128'h7876305470767D23993C375B4B3934F1;
  localparam logic [127:0] S78 = 128'hBC3804205138FF26EEEB9A39B31218A1;

  function automatic logic [127:0] subw(input logic [127:0] w);
    logic [127:0] o;
    int b;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      b = int'(w[8*k +: 8]);
      o[8*k +: 8] = SBOX[b*8 +: 8];
    end
    return o;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   req_valid;
  logic [255:0] req_data;

  logic [1:0]   rdy1, rv1, rdy3, rv3;
  logic [127:0] sbin1, sbm1, rd1, sbin3, sbm3, rd3;
  logic         sbv1, busy1, sbv3, busy3;

  sub_byte_arbiter #(.NUM_REQ(2), .SBOX_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_data(req_data),
    .sb_data_in(sbin1), .sb_valid(sbv1), .sb_sub_mat(sbm1),
    .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1));

  sub_byte_arbiter #(.NUM_REQ(2), .SBOX_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_data(req_data),
    .sb_data_in(sbin3), .sb_valid(sbv3), .sb_sub_mat(sbm3),
    .rsp_valid(rv3), .rsp_data(rd3), .busy(busy3));

  // S-box models with the matching pipeline depth
  logic [127:0] sp1;
  logic [127:0] sp3 [3];
  always @(posedge clk) begin
    sp1    <= subw(sbin1);
    sp3[0] <= subw(sbin3);
    sp3[1] <= sp3[0];
    sp3[2] <= sp3[1];
  end
  assign sbm1 = sp1;
  assign sbm3 = sp3[2];

  // scoreboard
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    logic [W-1:0] e;
    if (exp_q1.size() > 0 && exp_q1[0][161:130] == 32'(cyc)) begin
      e = exp_q1.pop_front();
      chk("rsp1_valid", 128'(rv1), 128'(e[129:128]));
      chk("rsp1_data", rd1, e[127:0]);
    end else begin
      chk("rsp1_idle", 128'(rv1), 128'(2'b00));
    end
    if (exp_q3.size() > 0 && exp_q3[0][161:130] == 32'(cyc)) begin
      e = exp_q3.pop_front();
      chk("rsp3_valid", 128'(rv3), 128'(e[129:128]));
      chk("rsp3_data", rd3, e[127:0]);
    end else begin
      chk("rsp3_idle", 128'(rv3), 128'(2'b00));
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_rsp();
  endtask

  task automatic drive(input logic [1:0] v, input logic [127:0] d0, input logic [127:0] d1);
    req_valid = v;
    req_data  = {d1, d0};
  endtask

  task automatic expect_grant(input string tag, input logic [1:0] exp_rdy, input logic [127:0] exp_sub);
    #1;
    chk({tag, "_rdy1"}, 128'(rdy1), 128'(exp_rdy));
    chk({tag, "_rdy3"}, 128'(rdy3), 128'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      exp_q1.push_back({32'(cyc + 2), exp_rdy, exp_sub});
      exp_q3.push_back({32'(cyc + 4), exp_rdy, exp_sub});
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdy1"}, 128'(rdy1), '0);
    chk({tag, "_rdy3"}, 128'(rdy3), '0);
    chk({tag, "_sbv1"}, 128'(sbv1), '0);
    chk({tag, "_sbv3"}, 128'(sbv3), '0);
    chk({tag, "_sbin1"}, sbin1, '0);
    chk({tag, "_sbin3"}, sbin3, '0);
    chk({tag, "_rv1"}, 128'(rv1), '0);
    chk({tag, "_rv3"}, 128'(rv3), '0);
    chk({tag, "_rd1"}, rd1, '0);
    chk({tag, "_rd3"}, rd3, '0);
    chk({tag, "_busy1"}, 128'(busy1), '0);
    chk({tag, "_busy3"}, 128'(busy3), '0);
  endtask

  initial begin
    logic [1:0]   e2;
    logic [127:0] es;
    logic [127:0] vec  [5];
    logic [127:0] expv [5];

    vec[0] = VA;  vec[1] = VB;  vec[2] = V78;
    vec[3] = 128'h0123456789ABCDEFFEDCBA9876543210;
    vec[4] = 128'h00112233445566778899AABBCCDDEEFF;
    expv[0] = SA; expv[1] = SB; expv[2] = S78;
    expv[3] = subw(vec[3]);
    expv[4] = subw(vec[4]);

    // reset state, with both requesters presenting
    rst = 1'b0;
    drive(2'b11, VA, VB);
    #2;
    check_all_zero("reset");
    step();
    step();
    drive(2'b00, '0, '0);
    rst = 1'b1;

    // single word from requester 0
    drive(2'b01, VA, '0);
    expect_grant("t1", 2'b01, SA);
    step();
    drive(2'b00, '0, '0);
    chk("t1_sbv1", 128'(sbv1), 128'(1'b1));
    chk("t1_sbin1", sbin1, VA);
    chk("t1_busy1", 128'(busy1), 128'(1'b1));
    step();
    chk("t1_sbv1_off", 128'(sbv1), '0);
    step();
    chk("t1_busy1_idle", 128'(busy1), '0);
    chk("t1_busy3_run", 128'(busy3), 128'(1'b1));
    step();
    step();
    step();
    chk("t1_busy3_idle", 128'(busy3), '0);

    // continuous contention for 20 cycles
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, VA, VB);
`ifdef SUB_BYTE_ARB_RR_EN
      e2 = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      e2 = 2'b01;
`endif
      es = (e2 == 2'b01) ? SA : SB;
      expect_grant("t2", e2, es);
      step();
    end
    drive(2'b00, '0, '0);
    for (int k = 0; k < 5; k++) step();
    chk("t2_busy1_idle", 128'(busy1), '0);
    chk("t2_busy3_idle", 128'(busy3), '0);

    // back-to-back stream from requester 1
    for (int k = 0; k < 5; k++) begin
      drive(2'b10, '0, vec[k]);
      expect_grant("t4", 2'b10, expv[k]);
      step();
    end
    drive(2'b00, '0, '0);
    for (int k = 0; k < 5; k++) step();
    chk("t4_busy3_idle", 128'(busy3), '0);

    // asynchronous reset with words in flight
    drive(2'b01, VA, '0);
    expect_grant("t5a", 2'b01, SA);
    step();
    drive(2'b01, VB, '0);
    expect_grant("t5b", 2'b01, SB);
    step();
    drive(2'b11, VA, VB);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("t5_rst");
    exp_q1.delete();
    exp_q3.delete();
    step();
    step();
    drive(2'b00, '0, '0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) step();
    drive(2'b10, '0, V78);
    expect_grant("t5c", 2'b10, S78);
    step();
    drive(2'b00, '0, '0);
    for (int k = 0; k < 5; k++) step();
    chk("t5_busy3_idle", 128'(busy3), '0);

    // requester 0 withdraws just before its turn
    pulse_reset();
    drive(2'b11, VA, VB);
    expect_grant("t6a", 2'b01, SA);
    step();
    drive(2'b11, VA, VB);
`ifdef SUB_BYTE_ARB_RR_EN
    expect_grant("t6b", 2'b10, SB);
    step();
    drive(2'b10, '0, V78);
    expect_grant("t6c", 2'b10, S78);
`else
    expect_grant("t6b", 2'b01, SA);
    step();
    drive(2'b10, '0, VB);
    expect_grant("t6c", 2'b10, SB);
`endif
    step();
    drive(2'b00, '0, '0);
    for (int k = 0; k < 6; k++) step();
    chk("t6_busy1_idle", 128'(busy1), '0);
    chk("t6_busy3_idle", 128'(busy3), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
